// File: rtl/dnram_pkg.sv
// dnram_pkg: shared definitions for the dnram storage primitive.
//   RD_FIRST / WR_FIRST : read-during-write ordering selectors for RD_MODE
//   clr_state_t         : states of the optional init-clear sequencer
//   lane_merge()        : byte-lane merge of a write into an existing word
package dnram_pkg;

  localparam int unsigned RD_FIRST = 0;
  localparam int unsigned WR_FIRST = 1;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clr_state_t;

  // lane_merge works on words up to MERGE_MAX_W bits; callers zero-extend
  // their operands and keep the low WIDTH bits of the result.
  localparam int unsigned MERGE_MAX_W = 512;
  localparam int unsigned MERGE_AW    = $clog2(MERGE_MAX_W);

  function automatic logic [MERGE_MAX_W-1:0] lane_merge(
    input logic [MERGE_MAX_W-1:0] old_word,
    input logic [MERGE_MAX_W-1:0] new_word,
    input logic [MERGE_MAX_W-1:0] be,
    input int unsigned            byte_w
  );
    logic [MERGE_MAX_W-1:0] res;
    logic [MERGE_AW-1:0]    bit_i;
    logic [MERGE_AW-1:0]    lane_i;
    res = old_word;
    for (int unsigned i = 0; i < MERGE_MAX_W; i++) begin
      bit_i  = MERGE_AW'(i);
      lane_i = MERGE_AW'(i / byte_w);
      if (be[lane_i]) res[bit_i] = new_word[bit_i];
    end
    return res;
  endfunction

endpackage

// File: rtl/dnram_rpipe.sv
// dnram_rpipe: per-port read delay line of DEPTH stages carrying {valid, data}.
//   clk       : clock
//   flush     : synchronous clear of every stage
//   in_valid  : read issued this cycle
//   in_data   : word sampled from the array this cycle
//   out_valid : valid DEPTH cycles after issue (combinational when DEPTH=0)
//   out_data  : data DEPTH cycles after issue
module dnram_rpipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  if (DEPTH == 0) begin : g_comb
    logic unused_ctl;
    assign unused_ctl = clk ^ flush;
    assign out_valid  = in_valid;
    assign out_data   = in_data;
  end else begin : g_reg
    localparam int unsigned DW = DEPTH * WIDTH;
    logic [DEPTH-1:0]            v_q;
    logic [DEPTH-1:0][WIDTH-1:0] d_q;

    // Shift toward the top index; the oldest entry falls off the end.
    always_ff @(posedge clk) begin
      if (flush) begin
        v_q <= '0;
        d_q <= '0;
      end else begin
        v_q <= DEPTH'({v_q, in_valid});
        d_q <= DW'({d_q, in_data});
      end
    end

    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
  end

endmodule

// File: rtl/dnram.sv
// dnram: parametrised RAM, one byte-enabled write port, NRD read ports with
// RD_DELAY (0..2) cycles of latency and a per-port rvalid qualifier.
//   clk    : clock
//   rst    : synchronous active-high reset
//   wen    : write enable         waddr : write address   wdata : write data
//   wbe    : byte-lane enables (BE_N = WIDTH/BYTE_W)
//   ren    : per-port read enable raddr : per-port read address
//   rdata  : per-port read data, zero whenever rvalid is low
//   rvalid : per-port read-data valid
//   busy   : array unavailable while the init clear runs
// Optional build macro DNRAM_INIT_CLEAR_EN: rst leaves the array untouched and
// starts a one-entry-per-cycle clear sequence; otherwise rst zeroes the array
// in one cycle and busy is tied low.
module dnram
  import dnram_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned SIZE     = 32,
  parameter int unsigned NRD      = 2,
  parameter int unsigned RD_DELAY = 1,
  parameter int unsigned RD_MODE  = 0,
  parameter int unsigned BYTE_W   = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wen,
  input  logic [$clog2(SIZE)-1:0]            waddr,
  input  logic [WIDTH-1:0]                   wdata,
  input  logic [WIDTH/BYTE_W-1:0]            wbe,
  input  logic [NRD-1:0]                     ren,
  input  logic [NRD-1:0][$clog2(SIZE)-1:0]   raddr,
  output logic [NRD-1:0][WIDTH-1:0]          rdata,
  output logic [NRD-1:0]                     rvalid,
  output logic                               busy
);

  localparam int unsigned AW   = $clog2(SIZE);
  localparam int unsigned BE_N = WIDTH / BYTE_W;
  localparam logic [AW:0] SIZE_L = (AW+1)'(SIZE);

  logic [WIDTH-1:0] mem [SIZE];

  logic             wr_ok;
  logic             rd_gate;
  logic [WIDTH-1:0] wr_old;
  logic [WIDTH-1:0] wmerged;
  logic [MERGE_MAX_W-1:0] m_old, m_new, m_be, m_res;
  logic             unused_merge_hi;

  // Widening by one bit keeps the compare meaningful when SIZE is a power of two.
  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < SIZE_L;
  endfunction

  assign wr_old = in_range(waddr) ? mem[waddr] : '0;

  always_comb begin
    m_old = '0;
    m_new = '0;
    m_be  = '0;
    m_old[WIDTH-1:0] = wr_old;
    m_new[WIDTH-1:0] = wdata;
    m_be[BE_N-1:0]   = wbe;
    m_res   = lane_merge(m_old, m_new, m_be, BYTE_W);
    wmerged = m_res[WIDTH-1:0];
  end
  assign unused_merge_hi = ^m_res[MERGE_MAX_W-1:WIDTH];

  assign wr_ok   = wen & ~rst & ~busy & in_range(waddr);
  assign rd_gate = ~rst & ~busy;

`ifdef DNRAM_INIT_CLEAR_EN
  localparam logic [AW-1:0] LAST = AW'(SIZE - 1);

  clr_state_t       state_q, state_d;
  logic [AW-1:0]    clr_ptr_q, clr_ptr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    busy      = 1'b0;
    case (state_q)
      CLEAR: begin
        busy = 1'b1;
        if (clr_ptr_q == LAST) begin
          state_d   = IDLE;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      IDLE: ;
    endcase
  end

  // No reset term on the array so it stays RAM-inferable; clearing is sequenced.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) mem[clr_ptr_q] <= '0;
      else if (wr_ok)       mem[waddr]     <= wmerged;
    end
  end
`else
  assign busy = 1'b0;

  always_ff @(posedge clk) begin
    if (rst)        mem        <= '{default: '0};
    else if (wr_ok) mem[waddr] <= wmerged;
  end
`endif

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic             issue;
    logic             hit;
    logic [WIDTH-1:0] word;
    logic             pipe_valid;
    logic [WIDTH-1:0] pipe_data;

    assign issue = ren[p] & rd_gate;
    assign hit   = (RD_MODE == WR_FIRST) && wr_ok && (raddr[p] == waddr);

    // Sampled in the issue cycle; later writes cannot reach data in flight.
    always_comb begin
      word = '0;
      if (issue) begin
        if (hit)                     word = wmerged;
        else if (in_range(raddr[p])) word = mem[raddr[p]];
      end
    end

    dnram_rpipe #(
      .WIDTH(WIDTH),
      .DEPTH(RD_DELAY)
    ) u_pipe (
      .clk      (clk),
      .flush    (rst),
      .in_valid (issue),
      .in_data  (word),
      .out_valid(pipe_valid),
      .out_data (pipe_data)
    );

    assign rvalid[p] = pipe_valid & ~rst;
    assign rdata[p]  = rvalid[p] ? pipe_data : '0;
  end

endmodule

// File: tb/tb_dnram.sv
module tb_dnram;

  logic             clk = 1'b0;
  logic             rst, wen;
  logic [4:0]       waddr;
  logic [15:0]      wdata;
  logic [1:0]       wbe, ren;
  logic [1:0][4:0]  raddr;
  logic [1:0][15:0] rd0, rd1, rd2;
  logic [1:0]       rv0, rv1, rv2;
  logic             bz0, bz1, bz2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // u0: delay 0 write-first; u1: delay 1 read-first; u2: delay 2 write-first, SIZE 20
  dnram #(.WIDTH(16), .SIZE(32), .NRD(2), .RD_DELAY(0), .RD_MODE(1), .BYTE_W(8)) u0 (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .ren(ren), .raddr(raddr), .rdata(rd0), .rvalid(rv0), .busy(bz0));
  dnram #(.WIDTH(16), .SIZE(32), .NRD(2), .RD_DELAY(1), .RD_MODE(0), .BYTE_W(8)) u1 (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .ren(ren), .raddr(raddr), .rdata(rd1), .rvalid(rv1), .busy(bz1));
  dnram #(.WIDTH(16), .SIZE(20), .NRD(2), .RD_DELAY(2), .RD_MODE(1), .BYTE_W(8)) u2 (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .ren(ren), .raddr(raddr), .rdata(rd2), .rvalid(rv2), .busy(bz2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d, input logic [1:0] b);
    waddr = a; wdata = d; wbe = b; wen = 1'b1;
    tick;
    wen = 1'b0;
  endtask

  task automatic test_reset;
    int n1, n2;
    rst = 1'b1; wen = 1'b0; ren = 2'b11; raddr[0] = 5'd0; raddr[1] = 5'd5;
    tick; tick;
    @(negedge clk);
    vectors++; if ({rv0, rd0} !== 34'h0) begin miscompares++; $display("FAIL rst_out_u0: got %h want 0", {rv0, rd0}); end
    vectors++; if ({rv1, rd1} !== 34'h0) begin miscompares++; $display("FAIL rst_out_u1: got %h want 0", {rv1, rd1}); end
    vectors++; if ({rv2, rd2} !== 34'h0) begin miscompares++; $display("FAIL rst_out_u2: got %h want 0", {rv2, rd2}); end
    rst = 1'b0; ren = 2'b00;
`ifdef DNRAM_INIT_CLEAR_EN
    n1 = 0; n2 = 0;
    ren = 2'b11;
    for (int i = 0; i < 64; i++) begin
      if (bz1) n1++;
      if (bz2) n2++;
      if (i < 3) begin
        vectors++; if ({rv0, rv1, rv2} !== 6'b0) begin miscompares++; $display("FAIL clear_ignores_ren: got %b want 000000", {rv0, rv1, rv2}); end
      end
      if (i == 2) ren = 2'b00;
      @(negedge clk);
    end
    vectors++; if (n1 !== 32) begin miscompares++; $display("FAIL busy_len_u1: got %0d want 32", n1); end
    vectors++; if (n2 !== 20) begin miscompares++; $display("FAIL busy_len_u2: got %0d want 20", n2); end
`else
    vectors++; if ({bz0, bz1, bz2} !== 3'b000) begin miscompares++; $display("FAIL busy_tied: got %b want 000", {bz0, bz1, bz2}); end
`endif
    tick;
    ren = 2'b11; raddr[0] = 5'd0; raddr[1] = 5'd5;
    @(negedge clk);
    vectors++; if ({rv0, rd0} !== {2'b11, 32'h0}) begin miscompares++; $display("FAIL rst_read_u0: got %h want %h", {rv0, rd0}, {2'b11, 32'h0}); end
    tick; ren = 2'b00;
    @(negedge clk);
    vectors++; if ({rv1, rd1} !== {2'b11, 32'h0}) begin miscompares++; $display("FAIL rst_read_u1: got %h want %h", {rv1, rd1}, {2'b11, 32'h0}); end
    vectors++; if ({rv0, rd0} !== 34'h0) begin miscompares++; $display("FAIL idle_u0: got %h want 0", {rv0, rd0}); end
    tick;
    @(negedge clk);
    vectors++; if ({rv2, rd2} !== {2'b11, 32'h0}) begin miscompares++; $display("FAIL rst_read_u2: got %h want %h", {rv2, rd2}, {2'b11, 32'h0}); end
    vectors++; if ({rv1, rd1} !== 34'h0) begin miscompares++; $display("FAIL idle_u1: got %h want 0", {rv1, rd1}); end
    tick;
  endtask

  task automatic test_byte_enable;
    wr(5'd3, 16'hAAAA, 2'b11);
    wr(5'd3, 16'h1234, 2'b01);
    wr(5'd3, 16'hFFFF, 2'b00);
    ren = 2'b01; raddr[0] = 5'd3;
    @(negedge clk);
    vectors++; if ({rv0, rd0} !== {2'b01, 16'h0, 16'hAA34}) begin miscompares++; $display("FAIL be_u0: got %h want %h", {rv0, rd0}, {2'b01, 16'h0, 16'hAA34}); end
    tick; ren = 2'b00;
    @(negedge clk);
    vectors++; if ({rv1, rd1} !== {2'b01, 16'h0, 16'hAA34}) begin miscompares++; $display("FAIL be_u1: got %h want %h", {rv1, rd1}, {2'b01, 16'h0, 16'hAA34}); end
    tick;
    @(negedge clk);
    vectors++; if ({rv2, rd2} !== {2'b01, 16'h0, 16'hAA34}) begin miscompares++; $display("FAIL be_u2: got %h want %h", {rv2, rd2}, {2'b01, 16'h0, 16'hAA34}); end
    tick;
  endtask

  task automatic test_collision;
    wr(5'd7, 16'h0001, 2'b11);
    wen = 1'b1; waddr = 5'd7; wdata = 16'hBEEF; wbe = 2'b11;
    ren = 2'b11; raddr[0] = 5'd7; raddr[1] = 5'd7;
    @(negedge clk);
    vectors++; if ({rv0, rd0} !== {2'b11, 16'hBEEF, 16'hBEEF}) begin miscompares++; $display("FAIL coll_wf_d0: got %h want %h", {rv0, rd0}, {2'b11, 16'hBEEF, 16'hBEEF}); end
    tick; wen = 1'b0; ren = 2'b00;
    @(negedge clk);
    vectors++; if ({rv1, rd1} !== {2'b11, 16'h0001, 16'h0001}) begin miscompares++; $display("FAIL coll_rf_d1: got %h want %h", {rv1, rd1}, {2'b11, 16'h0001, 16'h0001}); end
    tick;
    @(negedge clk);
    vectors++; if ({rv2, rd2} !== {2'b11, 16'hBEEF, 16'hBEEF}) begin miscompares++; $display("FAIL coll_wf_d2: got %h want %h", {rv2, rd2}, {2'b11, 16'hBEEF, 16'hBEEF}); end
    tick;
    // Partial-lane collision, then a full write right after issue.
    wen = 1'b1; waddr = 5'd7; wdata = 16'h12CD; wbe = 2'b01; ren = 2'b01; raddr[0] = 5'd7;
    @(negedge clk);
    vectors++; if ({rv0, rd0} !== {2'b01, 16'h0, 16'hBECD}) begin miscompares++; $display("FAIL coll_merge_d0: got %h want %h", {rv0, rd0}, {2'b01, 16'h0, 16'hBECD}); end
    tick; wdata = 16'h5555; wbe = 2'b11; ren = 2'b00;
    @(negedge clk);
    vectors++; if ({rv1, rd1} !== {2'b01, 16'h0, 16'hBEEF}) begin miscompares++; $display("FAIL coll_old_d1: got %h want %h", {rv1, rd1}, {2'b01, 16'h0, 16'hBEEF}); end
    vectors++; if ({rv0, rd0} !== 34'h0) begin miscompares++; $display("FAIL no_read_bypass_d0: got %h want 0", {rv0, rd0}); end
    tick; wen = 1'b0;
    @(negedge clk);
    vectors++; if ({rv2, rd2} !== {2'b01, 16'h0, 16'hBECD}) begin miscompares++; $display("FAIL inflight_d2: got %h want %h", {rv2, rd2}, {2'b01, 16'h0, 16'hBECD}); end
    tick;
  endtask

  task automatic test_streaming;
    logic        v;
    logic [15:0] d;
    for (int a = 0; a < 8; a++) wr(5'(a), 16'(16'h0100 + a), 2'b11);
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin ren = 2'b01; raddr[0] = 5'(c); end
      else ren = 2'b00;
      @(negedge clk);
      v = (c < 8); d = v ? 16'(16'h0100 + c) : 16'h0;
      vectors++; if ({rv0, rd0} !== {1'b0, v, 16'h0, d}) begin miscompares++; $display("FAIL stream_d0 c=%0d: got %h want %h", c, {rv0, rd0}, {1'b0, v, 16'h0, d}); end
      v = (c >= 1 && c <= 8); d = v ? 16'(16'h0100 + c - 1) : 16'h0;
      vectors++; if ({rv1, rd1} !== {1'b0, v, 16'h0, d}) begin miscompares++; $display("FAIL stream_d1 c=%0d: got %h want %h", c, {rv1, rd1}, {1'b0, v, 16'h0, d}); end
      v = (c >= 2 && c <= 9); d = v ? 16'(16'h0100 + c - 2) : 16'h0;
      vectors++; if ({rv2, rd2} !== {1'b0, v, 16'h0, d}) begin miscompares++; $display("FAIL stream_d2 c=%0d: got %h want %h", c, {rv2, rd2}, {1'b0, v, 16'h0, d}); end
      tick;
    end
  endtask

  task automatic test_out_of_range;
    wen = 1'b1; waddr = 5'd25; wdata = 16'hDEAD; wbe = 2'b11;
    ren = 2'b11; raddr[0] = 5'd5; raddr[1] = 5'd25;
    @(negedge clk);
    vectors++; if ({rv0, rd0} !== {2'b11, 16'hDEAD, 16'h0105}) begin miscompares++; $display("FAIL oor_coll_u0: got %h want %h", {rv0, rd0}, {2'b11, 16'hDEAD, 16'h0105}); end
    tick; wen = 1'b0; ren = 2'b00;
    @(negedge clk);
    vectors++; if ({rv1, rd1} !== {2'b11, 16'h0000, 16'h0105}) begin miscompares++; $display("FAIL oor_coll_u1: got %h want %h", {rv1, rd1}, {2'b11, 16'h0000, 16'h0105}); end
    tick;
    @(negedge clk);
    vectors++; if ({rv2, rd2} !== {2'b11, 16'h0000, 16'h0105}) begin miscompares++; $display("FAIL oor_coll_u2: got %h want %h", {rv2, rd2}, {2'b11, 16'h0000, 16'h0105}); end
    tick;
    ren = 2'b11; raddr[0] = 5'd5; raddr[1] = 5'd25;
    tick; ren = 2'b11; raddr[0] = 5'd19; raddr[1] = 5'd31;
    @(negedge clk);
    vectors++; if ({rv1, rd1} !== {2'b11, 16'hDEAD, 16'h0105}) begin miscompares++; $display("FAIL oor_rd_u1: got %h want %h", {rv1, rd1}, {2'b11, 16'hDEAD, 16'h0105}); end
    tick; ren = 2'b00;
    @(negedge clk);
    vectors++; if ({rv2, rd2} !== {2'b11, 16'h0000, 16'h0105}) begin miscompares++; $display("FAIL oor_rd_u2: got %h want %h", {rv2, rd2}, {2'b11, 16'h0000, 16'h0105}); end
    tick;
    @(negedge clk);
    vectors++; if ({rv2, rd2} !== {2'b11, 32'h0}) begin miscompares++; $display("FAIL oor_edge_u2: got %h want %h", {rv2, rd2}, {2'b11, 32'h0}); end
    tick;
  endtask

  task automatic test_reset_midflight;
    wr(5'd9, 16'h9999, 2'b11);
    ren = 2'b11; raddr[0] = 5'd9; raddr[1] = 5'd9;
    @(negedge clk);
    vectors++; if ({rv0, rd0} !== {2'b11, 16'h9999, 16'h9999}) begin miscompares++; $display("FAIL mid_issue_u0: got %h want %h", {rv0, rd0}, {2'b11, 16'h9999, 16'h9999}); end
    tick;
    rst = 1'b1; ren = 2'b00; wen = 1'b1; waddr = 5'd10; wdata = 16'h7777; wbe = 2'b11;
    @(negedge clk);
    vectors++; if ({rv1, rd1} !== 34'h0) begin miscompares++; $display("FAIL mid_rst_u1: got %h want 0", {rv1, rd1}); end
    vectors++; if ({rv2, rd2} !== 34'h0) begin miscompares++; $display("FAIL mid_rst_u2: got %h want 0", {rv2, rd2}); end
    tick; rst = 1'b0; wen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if ({rv1, rd1, rv2, rd2} !== 68'h0) begin miscompares++; $display("FAIL mid_flush i=%0d: got %h want 0", i, {rv1, rd1, rv2, rd2}); end
      tick;
    end
    for (int i = 0; i < 64 && (bz0 || bz1 || bz2); i++) tick;
    vectors++; if ({bz0, bz1, bz2} !== 3'b000) begin miscompares++; $display("FAIL busy_timeout: got %b want 000", {bz0, bz1, bz2}); end
    ren = 2'b11; raddr[0] = 5'd9; raddr[1] = 5'd10;
    @(negedge clk);
    vectors++; if ({rv0, rd0} !== {2'b11, 32'h0}) begin miscompares++; $display("FAIL mid_array_u0: got %h want %h", {rv0, rd0}, {2'b11, 32'h0}); end
    tick; ren = 2'b00;
    @(negedge clk);
    vectors++; if ({rv1, rd1} !== {2'b11, 32'h0}) begin miscompares++; $display("FAIL mid_array_u1: got %h want %h", {rv1, rd1}, {2'b11, 32'h0}); end
    tick;
    @(negedge clk);
    vectors++; if ({rv2, rd2} !== {2'b11, 32'h0}) begin miscompares++; $display("FAIL mid_array_u2: got %h want %h", {rv2, rd2}, {2'b11, 32'h0}); end
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0; wbe = '0; ren = '0; raddr = '0;
    test_reset;
    test_byte_enable;
    test_collision;
    test_streaming;
    test_out_of_range;
    test_reset_midflight;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
